// File: rtl/cic_pkg.sv
// Shared CIC sizing helpers: bit growth, internal register width and rate clamping.
// Constant functions so every module derives identical widths from its own parameters.
package cic_pkg;

   localparam int RATE_MIN = 2;

   function automatic int cic_clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   function automatic int cic_growth(input int n, input int m, input int maxrate);
      return n * cic_clog2(maxrate * m);
   endfunction

   function automatic int cic_iw(input int din, input int n, input int m, input int maxrate);
      return din + cic_growth(n, m, maxrate);
   endfunction

   function automatic int cic_clamp_rate(input int rate, input int maxrate);
      if (rate < RATE_MIN) return RATE_MIN;
      if (rate > maxrate) return maxrate;
      return rate;
   endfunction

endpackage

// File: rtl/cic_mc_channel.sv
// One CIC decimator channel: integrators at the input rate, combs once per strobe.
// data_o is the truncated comb result, registered one clock after the strobe.
module cic_mc_channel
   import cic_pkg::*;
#(
   parameter int DATAIN_WIDTH  = 16,
   parameter int DATAOUT_WIDTH = 25,
   parameter int CIC_N         = 5,
   parameter int CIC_M         = 2,
   parameter int CIC_MAXRATE   = 512
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     integ_en_i,
   input  logic                     strobe_i,
   input  logic [DATAIN_WIDTH-1:0]  data_i,
   output logic [DATAOUT_WIDTH-1:0] data_o
);

   localparam int IW = cic_iw(DATAIN_WIDTH, CIC_N, CIC_M, CIC_MAXRATE);

   logic [IW-1:0]            integ_q [CIC_N];
   logic [IW-1:0]            integ_d [CIC_N];
   logic [IW-1:0]            dly_q   [CIC_N][CIC_M];
   logic [IW-1:0]            dly_d   [CIC_N][CIC_M];
   logic [IW-1:0]            comb_in [CIC_N];
   logic [IW-1:0]            comb_out;
   logic [DATAOUT_WIDTH-1:0] data_q;
   logic [DATAOUT_WIDTH-1:0] data_d;
   logic                     unused_lsb;

   always_comb begin
      integ_d = integ_q;
      if (integ_en_i) begin
         integ_d[0] = integ_q[0] + {{(IW-DATAIN_WIDTH){data_i[DATAIN_WIDTH-1]}}, data_i};
         for (int k = 1; k < CIC_N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
      end
   end

   // Comb chain is combinational off the last integrator; only its delay lines are state.
   always_comb begin
      comb_out = integ_q[CIC_N-1];
      for (int k = 0; k < CIC_N; k++) begin
         comb_in[k] = comb_out;
         comb_out   = comb_out - dly_q[k][CIC_M-1];
      end
   end

   always_comb begin
      dly_d  = dly_q;
      data_d = data_q;
      if (strobe_i) begin
         for (int k = 0; k < CIC_N; k++) begin
            dly_d[k][0] = comb_in[k];
            for (int j = 1; j < CIC_M; j++) dly_d[k][j] = dly_q[k][j-1];
         end
         data_d = comb_out[IW-1 -: DATAOUT_WIDTH];
      end
   end

   assign unused_lsb = ^comb_out[IW-DATAOUT_WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < CIC_N; k++) begin
            integ_q[k] <= '0;
            for (int j = 0; j < CIC_M; j++) dly_q[k][j] <= '0;
         end
         data_q <= '0;
      end else begin
         integ_q <= integ_d;
         dly_q   <= dly_d;
         data_q  <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/cic_decim_mc.sv
// Multichannel CIC decimator: one shared rate counter/strobe drives NCH channel filters.
// act_out_o is combinational on the strobe cycle; data_o/val_o follow one clock later.
module cic_decim_mc
   import cic_pkg::*;
#(
   parameter int NCH           = 2,
   parameter int DATAIN_WIDTH  = 16,
   parameter int DATAOUT_WIDTH = 25,
   parameter int CIC_N         = 5,
   parameter int CIC_M         = 2,
   parameter int CIC_MAXRATE   = 512,
   parameter int RATE_WIDTH    = 10
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   input  logic                           act_i,
   input  logic                           sync_i,
   input  logic [RATE_WIDTH-1:0]          rate_i,
   input  logic [NCH*DATAIN_WIDTH-1:0]    data_i,
   output logic [NCH*DATAOUT_WIDTH-1:0]   data_o,
   output logic                           act_out_o,
   output logic                           val_o
);

   localparam int CW = cic_clog2(CIC_MAXRATE + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] r_act_q, r_act_d;
   logic [CW-1:0] r_load;
   logic          val_q, val_d;
   logic          qual, wrap, strobe;

   // Rate is only sampled at frame boundaries so a frame in flight keeps its length.
   always_comb begin
      r_load  = CW'(cic_clamp_rate(int'(rate_i), CIC_MAXRATE));
      qual    = en_i & act_i;
      wrap    = qual & (cnt_q == r_act_q - CW'(1));
      strobe  = wrap & ~sync_i & ~rst_i;
      cnt_d   = cnt_q;
      r_act_d = r_act_q;
      if (en_i & sync_i) begin
         cnt_d   = '0;
         r_act_d = r_load;
      end else if (wrap) begin
         cnt_d   = '0;
         r_act_d = r_load;
      end else if (qual) begin
         cnt_d   = cnt_q + CW'(1);
      end
      val_d = strobe;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         r_act_q <= r_load;
         val_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         r_act_q <= r_act_d;
         val_q   <= val_d;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      cic_mc_channel #(
         .DATAIN_WIDTH  (DATAIN_WIDTH),
         .DATAOUT_WIDTH (DATAOUT_WIDTH),
         .CIC_N         (CIC_N),
         .CIC_M         (CIC_M),
         .CIC_MAXRATE   (CIC_MAXRATE)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .integ_en_i (qual),
         .strobe_i   (strobe),
         .data_i     (data_i[k*DATAIN_WIDTH +: DATAIN_WIDTH]),
         .data_o     (data_o[k*DATAOUT_WIDTH +: DATAOUT_WIDTH])
      );
   end

   assign act_out_o = strobe;
   assign val_o     = val_q;

endmodule

// File: tb/tb_cic_decim_mc.sv
// Directed bench for cic_decim_mc: stimulus queues expected strobe gaps and outputs,
// an independent negedge monitor pops and compares them as the DUT produces them.
module tb_cic_decim_mc;

   logic        clk;
   logic        rst;
   logic        en;
   logic        act;
   logic        sync;
   logic [9:0]  rate;
   logic [31:0] din;
   logic [49:0] dout;
   logic        act_out;
   logic        val;

   cic_decim_mc dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .act_i     (act),
      .sync_i    (sync),
      .rate_i    (rate),
      .data_i    (din),
      .data_o    (dout),
      .act_out_o (act_out),
      .val_o     (val)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit chk;
      int d0;
      int d1;
   } exp_t;

   exp_t exp_q[$];
   int   gap_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_ref = 0;
   bit   prev_act = 1'b0;
   exp_t mon_e;
   int   mon_g;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   function automatic int ch_out(input logic [49:0] d, input int k);
      logic signed [24:0] s;
      s = d[k*25 +: 25];
      return int'(s);
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (val || prev_act) check("val_after_strobe", int'(val), int'(prev_act));
      if (val) begin
         if (exp_q.size() == 0) begin
            check("unexpected_val", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) begin
               check("data_ch0", ch_out(dout, 0), mon_e.d0);
               check("data_ch1", ch_out(dout, 1), mon_e.d1);
            end
         end
      end
      if (act_out) begin
         if (gap_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            mon_g = gap_q.pop_front();
            check("strobe_gap", cyc - last_ref, mon_g);
         end
         last_ref = cyc;
      end
      if (rst || (en && sync)) last_ref = cyc;
      prev_act = act_out;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_frames(input int n, input int gap, input int ndc, input int v0, input int v1);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         gap_q.push_back(gap);
         e.chk = (i >= ndc);
         e.d0  = v0;
         e.d1  = v1;
         exp_q.push_back(e);
      end
   endtask

   task automatic set_data(input int v0, input int v1);
      din = {v1[15:0], v0[15:0]};
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      step(n);
      check("reset_ch0", ch_out(dout, 0), 0);
      check("reset_ch1", ch_out(dout, 1), 0);
      check("reset_val", int'(val), 0);
      check("reset_act_out", int'(act_out), 0);
      rst = 1'b0;
   endtask

   task automatic sync_pulse(input int new_rate, input bit act_on_sync);
      rate = new_rate[9:0];
      act  = act_on_sync;
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      act  = 1'b1;
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b1;
      act  = 1'b1;
      sync = 1'b0;
      rate = 10'd512;
      set_data(1000, 1000);

      // Full rate: gain 2^50, truncated by 2^41 -> 1000 * 512
      push_frames(14, 512, 11, 512000, 512000);
      do_reset(3);
      step(7168);

      // R=50: 1000 * 100^5 / 2^41 = 4.547 -> 4
      rate = 10'd50;
      push_frames(14, 50, 11, 4, 4);
      do_reset(1);
      step(700);

      // Rate change mid-frame takes effect only at the next wrap
      rate = 10'd512;
      push_frames(1, 512, 1, 0, 0);
      push_frames(2, 50, 2, 0, 0);
      do_reset(1);
      step(100);
      rate = 10'd50;
      step(512);

      // Clamping: 1 -> 2, 1000 -> 512
      push_frames(4, 2, 4, 0, 0);
      sync_pulse(1, 1'b0);
      step(8);
      push_frames(2, 512, 2, 0, 0);
      sync_pulse(1000, 1'b0);
      step(1024);

      // Sync on a would-be strobe suppresses it and restarts the frame
      push_frames(3, 50, 3, 0, 0);
      sync_pulse(50, 1'b0);
      step(99);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(100);

      // act_i toggling halves the strobe rate without changing the DC gain
      push_frames(14, 100, 11, 4, 4);
      sync_pulse(50, 1'b0);
      for (int off = 1; off <= 1400; off++) begin
         act = (off % 2 == 0);
         step(1);
      end

      // en_i low for 20 cycles stretches the frame and freezes the outputs
      gap_q.push_back(70);
      push_frames(2, 50, 0, 4, 4);
      exp_q.push_back('{chk: 1'b1, d0: 4, d1: 4});
      sync_pulse(50, 1'b0);
      step(30);
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("frozen_act_out", int'(act_out), 0);
         check("frozen_val", int'(val), 0);
         check("frozen_ch0", ch_out(dout, 0), 4);
         check("frozen_ch1", ch_out(dout, 1), 4);
      end
      en = 1'b1;
      step(140);

      // Reset mid-frame, channels of opposite sign
      set_data(1000, -1000);
      rate = 10'd512;
      push_frames(14, 512, 11, 512000, -512000);
      do_reset(1);
      step(7168);

      step(3);
      check("pending_outputs", exp_q.size(), 0);
      check("pending_strobes", gap_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cic_decim_mc.md
CIC_DECIM_MC -- requirements
Module: cic_decim_mc

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent channels sharing one decimation strobe.
REQ-002 SHALL have parameter DATAIN_WIDTH, default 16, signed input sample width per channel.
REQ-003 SHALL have parameter DATAOUT_WIDTH, default 25, signed output width per channel.
REQ-004 SHALL have parameters CIC_N (default 5, stages), CIC_M (default 2, differential delay) and CIC_MAXRATE (default 512, maximum decimation rate).
REQ-005 SHALL have parameter RATE_WIDTH, default 10, width of rate_i.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port en_i, input, 1: global enable.
REQ-009 SHALL have port act_i, input, 1: input sample valid.
REQ-010 SHALL have port sync_i, input, 1: restart decimation phase.
REQ-011 SHALL have port rate_i, input, RATE_WIDTH: requested decimation rate R.
REQ-012 SHALL have port data_i, input, NCH*DATAIN_WIDTH: channel k at bits [k*DATAIN_WIDTH +: DATAIN_WIDTH].
REQ-013 SHALL have port data_o, output, NCH*DATAOUT_WIDTH: packed the same way.
REQ-014 SHALL have port act_out_o, output, 1: internal decimation strobe, for downstream blocks.
REQ-015 SHALL have port val_o, output, 1: data_o valid for one cycle.

Function
REQ-016 Internal width SHALL be IW = DATAIN_WIDTH + CIC_N*ceil(log2(CIC_MAXRATE*CIC_M)); integrators and combs wrap modulo 2^IW.
REQ-017 Each channel SHALL run CIC_N cascaded registered integrators, updated only on cycles with en_i=1 and act_i=1; otherwise they hold.
REQ-018 A rate counter SHALL advance on each en_i&act_i cycle; act_out_o SHALL be asserted combinationally on the cycle where counter == R_active-1 and act_i=1; the counter then returns to 0.
REQ-019 R_active SHALL load from rate_i only at counter wrap, on sync_i, or at reset; values below 2 load as 2, values above CIC_MAXRATE load as CIC_MAXRATE.
REQ-020 On act_out_o, the CIC_N comb stages (delay CIC_M decimated samples) SHALL update once; data_o and val_o SHALL register exactly one clock after the act_out_o cycle.
REQ-021 data_o per channel SHALL be comb output bits [IW-1 : IW-DATAOUT_WIDTH] (truncation, no rounding); gain is (R*M)^N, unnormalised below CIC_MAXRATE.
REQ-022 sync_i=1 SHALL clear the rate counter and load R_active; if it coincides with a would-be strobe, sync_i wins: no act_out_o, no val_o.
REQ-023 en_i=0 SHALL freeze all state, force act_out_o=0 and val_o=0 on the next edge; data_o holds.

Reset
REQ-024 On rst_i=1 at a clock edge, integrators, comb delays, rate counter, data_o, and val_o SHALL clear to 0, and R_active SHALL load the clamped rate_i; rst_i overrides every other input.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first act_out_o after reset occurs after R_active qualified act_i cycles.

Structure
REQ-026 IW, growth G, clog2 function and clamp constants SHALL live in a shared package cic_pkg.
REQ-027 A sub-module cic_mc_channel (integrators + combs + truncation for one channel) SHALL be instantiated NCH times; the rate counter and strobe stay in the top.

Verification
REQ-028 Defaults, rate_i=512, act_i=1, all channels DC 1000 -> from 12th val_o on, every channel data_o = 512000.
REQ-029 rate_i=50, DC 1000 -> settled data_o = 4; act_out_o period exactly 50 cycles, val_o one cycle later.
REQ-030 rate_i changed 512->50 mid-frame -> current frame completes at 512, next at 50; rate_i=1 -> period 2; rate_i=1000 -> period 512.
REQ-031 sync_i pulsed on the strobe cycle -> no val_o that cycle; next act_out_o exactly R cycles later.
REQ-032 act_i toggling 1/0 at rate_i=50 -> act_out_o every 100 cycles, DC output unchanged; en_i low 20 cycles -> all outputs frozen, val_o=0.
REQ-033 rst_i asserted mid-frame with channel 0 = +1000, channel 1 = -1000 -> all outputs 0 next edge; after re-settling, channel outputs +512000 / -512000 independently.
